// File: rtl/vga_timing_pkg.sv
// Shared constants and types for the 640x480@60 VGA timing controller.
package vga_timing_pkg;

  localparam int unsigned H_VISIBLE = 640;
  localparam int unsigned H_FRONT   = 16;
  localparam int unsigned H_SYNC    = 96;
  localparam int unsigned H_BACK    = 48;
  localparam int unsigned V_VISIBLE = 480;
  localparam int unsigned V_FRONT   = 10;
  localparam int unsigned V_SYNC    = 2;
  localparam int unsigned V_BACK    = 33;

  localparam int unsigned H_TOTAL     = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL     = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned HSYNC_START = H_VISIBLE + H_FRONT;
  localparam int unsigned HSYNC_END   = HSYNC_START + H_SYNC;
  localparam int unsigned VSYNC_START = V_VISIBLE + V_FRONT;
  localparam int unsigned VSYNC_END   = VSYNC_START + V_SYNC;

  localparam int unsigned CNT_W = 10;
  typedef logic [CNT_W-1:0] cnt_t;

  // Counter-width views of the timing points, so compares stay width-matched
  localparam cnt_t H_VIS_C       = CNT_W'(H_VISIBLE);
  localparam cnt_t H_LAST_C      = CNT_W'(H_TOTAL - 1);
  localparam cnt_t V_VIS_C       = CNT_W'(V_VISIBLE);
  localparam cnt_t V_LAST_C      = CNT_W'(V_TOTAL - 1);
  localparam cnt_t HSYNC_START_C = CNT_W'(HSYNC_START);
  localparam cnt_t HSYNC_END_C   = CNT_W'(HSYNC_END);
  localparam cnt_t VSYNC_START_C = CNT_W'(VSYNC_START);
  localparam cnt_t VSYNC_END_C   = CNT_W'(VSYNC_END);

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/vga_axis_counter.sv
// Wrap counter for one raster axis: counts 0..LAST on inc, resets to LAST.
module vga_axis_counter #(
  parameter int unsigned W    = 10,
  parameter int unsigned LAST = 799
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic [W-1:0] next_c,
  output logic         carry_c
);

  localparam logic [W-1:0] LAST_V = W'(LAST);

  always_comb begin
    carry_c = inc && (count == LAST_V);
    next_c  = count;
    if (inc) begin
      next_c = carry_c ? '0 : count + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= LAST_V;
    end else begin
      count <= next_c;
    end
  end

endmodule

// File: rtl/vga_timing_ctrl.sv
// 640x480@60 raster sequencer with sync decode and per-line prefetch handshake.
// Define VGA_LINE_FETCH_EN to build the fetch FSM and underrun flag.
module vga_timing_ctrl
  import vga_timing_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr_underrun,
  input  logic             fetch_ack,
  output logic [CNT_W-1:0] h_count,
  output logic [CNT_W-1:0] v_count,
  output logic             hsync,
  output logic             vsync,
  output logic             video_on,
  output logic             frame_start,
  output logic             fetch_req,
  output logic [CNT_W-1:0] fetch_line,
  output logic             underrun
);

  cnt_t h_next_c;
  cnt_t v_next_c;
  logic h_carry_c;
  logic v_carry_c;
  logic v_inc_c;

  assign v_inc_c = en & h_carry_c;

  vga_axis_counter #(.W(CNT_W), .LAST(H_TOTAL - 1)) u_h_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc     (en),
    .count   (h_count),
    .next_c  (h_next_c),
    .carry_c (h_carry_c)
  );

  vga_axis_counter #(.W(CNT_W), .LAST(V_TOTAL - 1)) u_v_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc     (v_inc_c),
    .count   (v_count),
    .next_c  (v_next_c),
    .carry_c (v_carry_c)
  );

  // Decode from next-count values so the flops line up with h_count/v_count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      video_on    <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      hsync       <= !((h_next_c >= HSYNC_START_C) && (h_next_c < HSYNC_END_C));
      vsync       <= !((v_next_c >= VSYNC_START_C) && (v_next_c < VSYNC_END_C));
      video_on    <= (h_next_c < H_VIS_C) && (v_next_c < V_VIS_C);
      frame_start <= v_carry_c;
    end
  end

`ifdef VGA_LINE_FETCH_EN

  fetch_state_t state_q;
  fetch_state_t state_d;
  cnt_t         line_d;
  cnt_t         nl_c;
  logic         underrun_d;
  logic         start_c;
  logic         deadline_c;

  always_comb begin
    state_d    = state_q;
    line_d     = fetch_line;
    underrun_d = underrun & ~clr_underrun;
    nl_c       = (v_count == V_LAST_C) ? '0 : v_count + CNT_W'(1);
    start_c    = en && (h_next_c == H_VIS_C) && (nl_c < V_VIS_C);
    deadline_c = en && (h_next_c == H_LAST_C);
    case (state_q)
      IDLE: begin
        if (start_c) begin
          state_d = REQ;
          line_d  = nl_c;
        end
      end
      REQ: begin
        // An ack coincident with the deadline tick still counts as on time
        if (fetch_ack) begin
          state_d = IDLE;
        end else if (deadline_c) begin
          state_d    = IDLE;
          underrun_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      fetch_req  <= 1'b0;
      fetch_line <= '0;
      underrun   <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_req  <= (state_d == REQ);
      fetch_line <= line_d;
      underrun   <= underrun_d;
    end
  end

`else

  wire unused_fetch_inputs = &{1'b0, fetch_ack, clr_underrun};

  assign fetch_req  = 1'b0;
  assign fetch_line = '0;
  assign underrun   = 1'b0;

`endif

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Randomized bench for vga_timing_ctrl against a raster-index reference model.
module tb_vga_timing_ctrl;

  localparam int FRAME = 800 * 525;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       clr_underrun;
  logic       fetch_ack;
  logic [9:0] h_count;
  logic [9:0] v_count;
  logic       hsync;
  logic       vsync;
  logic       video_on;
  logic       frame_start;
  logic       fetch_req;
  logic [9:0] fetch_line;
  logic       underrun;

  int total = 0;
  int bad   = 0;

  // Reference model: raster position as one linear pixel index into the frame
  int m_idx, m_h, m_v, m_line;
  bit m_hs, m_vs, m_vo, m_fs, m_req, m_unr;
  int req_age, mode, dly;

  vga_timing_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .clr_underrun (clr_underrun),
    .fetch_ack    (fetch_ack),
    .h_count      (h_count),
    .v_count      (v_count),
    .hsync        (hsync),
    .vsync        (vsync),
    .video_on     (video_on),
    .frame_start  (frame_start),
    .fetch_req    (fetch_req),
    .fetch_line   (fetch_line),
    .underrun     (underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_idx = FRAME - 1;
    m_h = 799; m_v = 524;
    m_hs = 1; m_vs = 1; m_vo = 0; m_fs = 0;
    m_req = 0; m_line = 0; m_unr = 0;
    req_age = 0;
  endtask

  task automatic model_update(input bit e, input bit a, input bit c);
    bit set;
    set = 0;
    if (e) m_idx = (m_idx + 1) % FRAME;
    m_h  = m_idx % 800;
    m_v  = m_idx / 800;
    m_fs = e && (m_idx == 0);
    m_hs = !(m_h >= 656 && m_h < 752);
    m_vs = !(m_v >= 490 && m_v < 492);
    m_vo = (m_h < 640) && (m_v < 480);
`ifdef VGA_LINE_FETCH_EN
    if (m_req) begin
      if (a) m_req = 0;
      else if (e && m_h == 799) begin
        m_req = 0;
        set = 1;
      end
    end else if (e && m_h == 640 && ((m_v + 1) % 525) < 480) begin
      m_req  = 1;
      m_line = (m_v + 1) % 525;
    end
    m_unr = set || (m_unr && !c);
`else
    m_unr = m_unr && !c && !a && !set;
`endif
  endtask

  task automatic check_all();
    check("h_count", int'(h_count), m_h);
    check("v_count", int'(v_count), m_v);
    check("hsync", int'(hsync), int'(m_hs));
    check("vsync", int'(vsync), int'(m_vs));
    check("video_on", int'(video_on), int'(m_vo));
    check("frame_start", int'(frame_start), int'(m_fs));
    check("fetch_req", int'(fetch_req), int'(m_req));
    if (m_req) check("fetch_line", int'(fetch_line), m_line);
    check("underrun", int'(underrun), int'(m_unr));
  endtask

  task automatic step(input bit e, input bit a, input bit c);
    en = e; fetch_ack = a; clr_underrun = c;
    @(posedge clk);
    model_update(e, a, c);
    @(negedge clk);
    check_all();
  endtask

  // Pixel source behaviour: per request pick never-ack, deadline-ack or delayed ack
  task automatic run(input int n, input bit rnd);
    for (int i = 0; i < n; i++) begin
      bit e, a, c;
      e = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      a = 1'b0;
      c = rnd && ($urandom_range(0, 199) == 0);
      if (m_req) begin
        if (req_age == 0) begin
          mode = rnd ? int'($urandom_range(0, 9)) : 5;
          dly  = rnd ? int'($urandom_range(1, 6)) : 3;
        end
        req_age++;
        if (mode == 1) begin
          if (m_h == 798) begin
            e = 1'b1;
            a = 1'b1;
          end
        end else if (mode != 0) begin
          a = (req_age == dly);
        end
      end else begin
        req_age = 0;
        a = rnd && ($urandom_range(0, 19) == 0);
      end
      step(e, a, c);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_h"}, int'(h_count), 799);
    check({tag, "_v"}, int'(v_count), 524);
    check({tag, "_hsync"}, int'(hsync), 1);
    check({tag, "_vsync"}, int'(vsync), 1);
    check({tag, "_video_on"}, int'(video_on), 0);
    check({tag, "_frame_start"}, int'(frame_start), 0);
    check({tag, "_fetch_req"}, int'(fetch_req), 0);
    check({tag, "_fetch_line"}, int'(fetch_line), 0);
    check({tag, "_underrun"}, int'(underrun), 0);
  endtask

  initial begin
    bit found;
    rst_n = 1'b0; en = 1'b0; fetch_ack = 1'b0; clr_underrun = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_state("rst");
    rst_n = 1'b1;
    step(1'b0, 1'b1, 1'b0);

    run(12000, 1'b0);
    run(55000, 1'b1);

    // Find a point mid-line with a request outstanding, then hit reset
    found = 0;
    for (int i = 0; i < 3000 && !found; i++) begin
`ifdef VGA_LINE_FETCH_EN
      if (m_h == 700 && m_req) found = 1;
`else
      if (m_h == 700) found = 1;
`endif
      if (!found) step(1'b1, 1'b0, 1'b0);
    end
    check("rst_search", int'(found), 1);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_reset_state("async_rst");
    @(negedge clk);
    check_reset_state("rst_hold");
    rst_n = 1'b1;
    run(4000, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
